// File: rtl/ifu_fetch.sv
// Instruction fetch unit: fetches a word at pc, presents it to the control unit, then steps or redirects the pc.
// Optional macro IFU_HALT_EN: accepting opcode 6'b111111 parks the unit in HALT until reset.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [5:0]  opcode,
  output logic [4:0]  funct,
  output logic [15:0] imm,
  output logic        valid,
  input  logic        ready,
  input  logic        jump,
  input  logic        branch,
  input  logic        cond,
  input  logic        flag,
  output logic [31:0] pc
);

`ifdef IFU_HALT_EN
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_ISSUE = 2'd1, S_HALT = 2'd2} state_e;
`else
  typedef enum logic {S_FETCH = 1'b0, S_ISSUE = 1'b1} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  logic [31:0] pc4;
  logic        redirect;
  logic [31:0] target;

  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] index);
    return {pc_plus4[31:28], index, 2'b00};
  endfunction

  function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                input logic [15:0] offset);
    logic signed [31:0] byte_off;
    byte_off = {{14{offset[15]}}, offset, 2'b00};
    return pc_plus4 + byte_off;
  endfunction

  assign pc4      = pc_q + 32'd4;
  assign redirect = (jump | branch) & (~cond | flag);
  // Jump wins when both redirect kinds are decoded together.
  assign target   = jump ? jump_target(pc4, instr_q[25:0])
                         : branch_target(pc4, instr_q[15:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    imem_req = 1'b0;
    valid    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_data;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        valid = 1'b1;
        if (ready) begin
          pc_d    = redirect ? target : pc4;
          state_d = S_FETCH;
`ifdef IFU_HALT_EN
          if (instr_q[31:26] == 6'b111111) state_d = S_HALT;
`endif
        end
      end
`ifdef IFU_HALT_EN
      S_HALT: begin
        state_d = S_HALT;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // Fields read as zero (a NOP) whenever nothing is being issued.
  assign opcode    = valid ? instr_q[31:26] : 6'd0;
  assign funct     = valid ? instr_q[4:0]   : 5'd0;
  assign imm       = valid ? instr_q[15:0]  : 16'd0;
  assign imem_addr = pc_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch: directed scenarios plus random traffic checked against a behavioural model.
module tb_ifu_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [5:0]  opcode;
  logic [4:0]  funct;
  logic [15:0] imm;
  logic        valid;
  logic        ready;
  logic        jump, branch, cond, flag;
  logic [31:0] pc;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: "waiting for a word", "holding a word", or "stopped".
  bit          m_wait_word = 1'b1;
  bit          m_stopped   = 1'b0;
  logic [31:0] m_pc        = RST_PC;
  logic [31:0] m_word      = 32'h0;

  ifu_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .opcode(opcode), .funct(funct),
    .imm(imm), .valid(valid), .ready(ready), .jump(jump), .branch(branch),
    .cond(cond), .flag(flag), .pc(pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] nxt, tgt;
    int          off;
    if (rst) begin
      m_wait_word = 1'b1; m_stopped = 1'b0; m_pc = RST_PC; m_word = 32'h0;
    end else if (m_stopped) begin
    end else if (m_wait_word) begin
      if (imem_ack) begin m_word = imem_data; m_wait_word = 1'b0; end
    end else if (ready) begin
      nxt = m_pc + 32'd4;
      if ((jump || branch) && (!cond || flag)) begin
        if (jump) tgt = (nxt & 32'hF000_0000) | (32'(m_word[25:0]) * 32'd4);
        else begin
          off = int'($signed(m_word[15:0]));
          tgt = nxt + 32'(off * 4);
        end
        nxt = tgt;
      end
      m_pc = nxt;
      m_wait_word = 1'b1;
`ifdef IFU_HALT_EN
      if (m_word[31:26] == 6'h3F) m_stopped = 1'b1;
`endif
    end
  endtask

  task automatic check_all();
    bit ev;
    ev = !m_wait_word && !m_stopped;
    chk("valid", valid, ev);
    chk("imem_req", imem_req, m_wait_word && !m_stopped);
    chk("imem_addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("opcode", opcode, ev ? m_word[31:26] : 6'd0);
    chk("funct", funct, ev ? m_word[4:0] : 5'd0);
    chk("imm", imm, ev ? m_word[15:0] : 16'd0);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_ctl(input logic j, input logic b, input logic c, input logic f);
    jump = j; branch = b; cond = c; flag = f;
  endtask

  // Fetch one word (ack in first fetch cycle) and accept it with the given controls.
  task automatic issue(input logic [31:0] w, input logic j, input logic b,
                       input logic c, input logic f);
    imem_ack = 1'b1; imem_data = w; ready = 1'b1; set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    imem_ack = 1'b1; imem_data = ~w; set_ctl(j, b, c, f);
    cycle();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0); imem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cycle(); cycle(); rst = 1'b0;
  endtask

  initial begin
    logic [31:0] a0, w;
    logic [5:0]  op0;
    logic [15:0] im0;
    logic [4:0]  fn0;
    rst = 1'b1; imem_ack = 1'b0; imem_data = 32'h0; ready = 1'b0;
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    imem_ack = 1'b1; imem_data = 32'h1234_5678; ready = 1'b1;
    cycle(); cycle();
    chk("rst_valid", valid, 1'b0);
    chk("rst_opcode", opcode, 6'd0);
    chk("rst_imm", imm, 16'd0);
    chk("rst_addr", imem_addr, RST_PC);
    rst = 1'b0;

    // Sequential fetch, ack always high
    for (int k = 1; k <= 8; k++) begin
      imem_data = $urandom & 32'h03FF_FFFF;
      cycle();
      chk("seq_addr", imem_addr, 32'(4 * (k / 2)));
      chk("seq_valid", valid, 32'(k % 2));
    end
    chk("seq_req", imem_req, 1'b1);

    // Conditional branch at 0x10, imm = -1
    issue(32'h0800_0004, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("jmp_to_10", imem_addr, 32'h10);
    issue(32'h1000_FFFF, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("br_not_taken", imem_addr, 32'h14);
    issue(32'h0800_0004, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(32'h1000_FFFF, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("br_taken", imem_addr, 32'h10);

    // Climb to 0x2000_0000 with maximal forward branches
    do_reset();
    for (int i = 0; i < 4096; i++) issue(32'h1000_7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("climb_pc", imem_addr, 32'h2000_0000);
    issue(32'h0800_0040, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("jump_region", imem_addr, 32'h2000_0100);
    issue(32'h0800_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("jump_back", imem_addr, 32'h2000_0000);
    issue(32'h0800_0040, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("jump_wins", imem_addr, 32'h2000_0100);

    // Wrap-around: branch back to 0xFFFFFFFC then step to 0
    do_reset();
    issue(32'h1000_FFFE, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("neg_wrap", imem_addr, 32'hFFFF_FFFC);
    issue(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pc_wrap", imem_addr, 32'h0);

    // Delayed ack and stalled ready
    a0 = imem_addr;
    imem_ack = 1'b0; ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_data = $urandom; cycle();
      chk("stall_fetch_addr", imem_addr, a0);
    end
    imem_ack = 1'b1; imem_data = 32'h2C5A_9E13; cycle();
    op0 = opcode; im0 = imm; fn0 = funct;
    chk("late_op", op0, 6'h0B);
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_ctl(1'($urandom), 1'($urandom), 1'b0, 1'($urandom));
      imem_ack = 1'($urandom); imem_data = $urandom;
      cycle();
      chk("hold_addr", imem_addr, a0);
      chk("hold_opcode", opcode, op0);
      chk("hold_imm", imm, im0);
      chk("hold_funct", funct, fn0);
    end
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0); ready = 1'b1; imem_ack = 1'b0;
    cycle();
    chk("one_advance", imem_addr, a0 + 32'd4);

    // Reset mid-issue with ready and jump, and mid-fetch with ack
    issue(32'h0800_0100, 1'b1, 1'b0, 1'b0, 1'b0);
    imem_ack = 1'b1; imem_data = 32'h0800_0033; cycle();
    rst = 1'b1; ready = 1'b1; set_ctl(1'b1, 1'b0, 1'b0, 1'b0); cycle(); rst = 1'b0;
    chk("rst_issue_addr", imem_addr, RST_PC);
    chk("rst_issue_valid", valid, 1'b0);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    issue(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; imem_ack = 1'b1; cycle(); rst = 1'b0;
    chk("rst_fetch_valid", valid, 1'b0);
    chk("rst_fetch_addr", imem_addr, RST_PC);

    // All-ones opcode
    issue(32'hFC00_0000, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef IFU_HALT_EN
    imem_ack = 1'b1; ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("halt_req", imem_req, 1'b0);
      chk("halt_pc", pc, 32'h4);
    end
    do_reset();
    chk("halt_exit", imem_req, 1'b1);
`else
    chk("op3f_step", imem_addr, 32'h4);
    chk("op3f_req", imem_req, 1'b1);
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      imem_ack = 1'($urandom);
      ready = 1'($urandom);
      w = $urandom;
      if (w[31:26] == 6'h3F && $urandom_range(0, 3) != 0) w[31] = 1'b0;
      imem_data = w;
      set_ctl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      cycle();
`ifdef IFU_HALT_EN
      if (m_stopped && $urandom_range(0, 4) == 0) begin rst = 1'b1; cycle(); end
`endif
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
